integracao_display: RTL and testbench

- Registered 6-bit-input to single 7-segment-digit decoder; integrates four combinational sub-functions selected by the input's upper two bits.
- Sits between a 6-bit switch/data bus and one 7-segment display.
- Output is registered on the clock, with asynchronous active-high reset.

---
 rtl/integracao_display.sv | 83 ++++++++
 tb/tb_integracao_display.sv | 128 ++++++++++++
 2 files changed

// File: rtl/integracao_display.sv
// Registered 6-bit to 7-segment decoder: hex, decimal units, decimal tens
// or popcount digit chosen by entrada[5:4], glyph captured every clock.
module integracao_display (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] entrada,
  output logic [6:0] segmentos
);

  typedef enum logic [1:0] {
    M_HEX   = 2'b00,
    M_UNITS = 2'b01,
    M_TENS  = 2'b10,
    M_POP   = 2'b11
  } mode_t;

  mode_t      w_mode;
  logic [3:0] w_val;
  logic       w_ge10;
  logic [3:0] w_units;
  logic [3:0] w_tens;
  logic [3:0] w_pop;
  logic [3:0] w_digit;
  logic [6:0] w_glyph;
  logic [6:0] r_seg;

  assign w_mode = mode_t'(entrada[5:4]);
  assign w_val  = entrada[3:0];

  // 4-bit values only reach 15, so one conditional subtract is a full mod 10
  assign w_ge10  = (w_val >= 4'd10);
  assign w_units = w_ge10 ? (w_val - 4'd10) : w_val;
  assign w_tens  = {3'b000, w_ge10};

  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < 6; i++) begin
      w_pop = w_pop + {3'b000, entrada[i]};
    end
  end

  always_comb begin
    w_digit = w_val;
    unique case (w_mode)
      M_HEX:   w_digit = w_val;
      M_UNITS: w_digit = w_units;
      M_TENS:  w_digit = w_tens;
      M_POP:   w_digit = w_pop;
      default: w_digit = w_val;
    endcase
  end

  always_comb begin
    w_glyph = 7'h00;
    unique case (w_digit)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      4'hF: w_glyph = 7'h71;
      default: w_glyph = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_seg <= 7'h00;
    else     r_seg <= w_glyph;
  end

  assign segmentos = r_seg;

endmodule

// File: tb/tb_integracao_display.sv
// Bench for integracao_display: directed plan, full sweep with mid-reset,
// and random inputs against an arithmetic reference model.
module tb_integracao_display;

  logic       clk;
  logic       rst;
  logic [5:0] entrada;
  logic [6:0] segmentos;

  int errs;
  int checks;

  logic [6:0] glyph [16];

  integracao_display dut (
    .clk       (clk),
    .rst       (rst),
    .entrada   (entrada),
    .segmentos (segmentos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [6:0] obs,
                     input logic [6:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [5:0] e);
    int v;
    int d;
    v = int'(e[3:0]);
    case (int'(e[5:4]))
      0: d = v;
      1: d = v % 10;
      2: d = v / 10;
      default: d = $countones(e);
    endcase
    return glyph[d];
  endfunction

  task automatic step(input logic [5:0] e, input string tag);
    @(negedge clk);
    entrada = e;
    @(posedge clk);
    #1;
    chk(tag, segmentos, ref_seg(e));
  endtask

  task automatic step_k(input logic [5:0] e,
                        input logic [6:0] k,
                        input string tag);
    @(negedge clk);
    entrada = e;
    @(posedge clk);
    #1;
    chk(tag, segmentos, k);
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    rst     = 1'b0;
    entrada = 6'd63;
    #2 rst = 1'b1;
    #1 chk("rst_async", segmentos, 7'h00);
    repeat (3) begin
      @(posedge clk);
      #1 chk("rst_hold", segmentos, 7'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_release", segmentos, 7'h7D);

    step_k(6'd0,  7'h3F, "hex0");
    step_k(6'd11, 7'h7C, "hex11");
    step_k(6'd15, 7'h71, "hex15");
    for (int i = 0; i < 16; i++) step(6'(i), "hex_sweep");

    step_k(6'd29, 7'h4F, "units13");
    step_k(6'd16, 7'h3F, "units0");
    step_k(6'd25, 7'h6F, "units9");
    step_k(6'd31, 7'h6D, "units15");

    step_k(6'd41, 7'h3F, "tens9");
    step_k(6'd42, 7'h06, "tens10");
    step_k(6'd46, 7'h06, "tens14");

    step_k(6'd48, 7'h5B, "pop2");
    step_k(6'd51, 7'h66, "pop4");
    step_k(6'd63, 7'h7D, "pop6");

    for (int i = 0; i < 64; i++) begin
      if (i == 37) begin
        @(negedge clk);
        entrada = 6'd37;
        #2 rst = 1'b1;
        #1 chk("mid_rst_async", segmentos, 7'h00);
        @(posedge clk);
        #1 chk("mid_rst_hold", segmentos, 7'h00);
        @(negedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1 chk("mid_rst_resume", segmentos, ref_seg(6'd37));
      end else begin
        step(6'(i), "sweep");
      end
    end

    for (int n = 0; n < 200; n++) begin
      step(6'($urandom_range(0, 63)), "random");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
